// File: rtl/shift_seq_gen_if.sv
// Control/status bundle for shift_seq_gen: step controls in, sequence state out.
interface shift_seq_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic             fix;

  modport master (
    output en, mode, dir, load, load_data,
    input  cnt, wrap, fix
  );

  modport slave (
    input  en, mode, dir, load, load_data,
    output cnt, wrap, fix
  );
endinterface

// File: rtl/shift_seq_gen.sv
// Multi-mode shift-sequence generator: Johnson, one-hot ring or Fibonacci LFSR,
// with parallel load, illegal-state self-correction and a wrap pulse.
module shift_seq_gen #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'h1D)
) (
  input logic           i_clk,
  input logic           i_rst,
  shift_seq_gen_if.slave bus
);

  localparam int unsigned EW = WIDTH - 1;

  localparam logic [1:0] MODE_JOHNSON = 2'b00;
  localparam logic [1:0] MODE_RING    = 2'b01;
  localparam logic [1:0] MODE_LFSR    = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  localparam logic [WIDTH-1:0] SEED = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic             r_fix;

  logic [EW-1:0]    w_edges;
  logic             w_legal;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic             w_fix_nxt;

  // Adjacent-bit transitions; a Johnson state has at most one.
  assign w_edges = r_cnt[WIDTH-1:1] ^ r_cnt[WIDTH-2:0];

  // Legality of the current state under the currently selected mode.
  always_comb begin
    w_legal = 1'b1;
    case (bus.mode)
      MODE_JOHNSON: w_legal = ((w_edges & (w_edges - EW'(1))) == '0);
      MODE_RING:    w_legal = (r_cnt != '0) && ((r_cnt & (r_cnt - SEED)) == '0);
      MODE_LFSR:    w_legal = (r_cnt != '0);
      default:      w_legal = 1'b1;
    endcase
  end

  // Successor state for one step in the selected mode and direction.
  always_comb begin
    w_step = r_cnt;
    case (bus.mode)
      MODE_JOHNSON: begin
        if (bus.dir) w_step = {r_cnt[WIDTH-2:0], ~r_cnt[WIDTH-1]};
        else         w_step = {~r_cnt[0], r_cnt[WIDTH-1:1]};
      end
      MODE_RING: begin
        if (bus.dir) w_step = {r_cnt[WIDTH-2:0], r_cnt[WIDTH-1]};
        else         w_step = {r_cnt[0], r_cnt[WIDTH-1:1]};
      end
      MODE_LFSR:    w_step = {^(r_cnt & LFSR_TAPS), r_cnt[WIDTH-1:1]};
      default:      w_step = r_cnt;
    endcase
  end

  // Edge priority below reset: load, then correction, then step, else hold.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    w_fix_nxt  = 1'b0;
    if (bus.load) begin
      w_cnt_nxt = bus.load_data;
    end else if ((bus.mode != MODE_HOLD) && !w_legal) begin
      w_cnt_nxt = SEED;
      w_fix_nxt = 1'b1;
    end else if (bus.en && (bus.mode != MODE_HOLD)) begin
      w_cnt_nxt  = w_step;
      w_wrap_nxt = (w_step == SEED);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= SEED;
      r_wrap <= 1'b0;
      r_fix  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
      r_fix  <= w_fix_nxt;
    end
  end

  assign bus.cnt  = r_cnt;
  assign bus.wrap = r_wrap;
  assign bus.fix  = r_fix;

endmodule

// File: tb/tb_shift_seq_gen.sv
// Directed self-checking bench for shift_seq_gen at WIDTH=8, default taps.
module tb_shift_seq_gen;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  shift_seq_gen_if #(.WIDTH(8)) bus ();

  shift_seq_gen #(.WIDTH(8), .LFSR_TAPS(8'h1D)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] johnson_exp [16] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
                                   8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] c, input logic w, input logic f);
    check({tag, ".cnt"}, 32'(bus.cnt), 32'(c));
    check({tag, ".wrap"}, 32'(bus.wrap), 32'(w));
    check({tag, ".fix"}, 32'(bus.fix), 32'(f));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] c);
    logic [7:0] t;
    t = c & 8'h1D;
    return {^t, c[7:1]};
  endfunction

  initial begin
    logic [7:0] model;
    int         wraps;
    int         zeros;
    int         distinct;
    bit         seen [256];

    n_checks = 0;
    n_errors = 0;
    rst           = 1'b1;
    bus.en        = 1'b1;
    bus.mode      = 2'b00;
    bus.dir       = 1'b0;
    bus.load      = 1'b0;
    bus.load_data = 8'h00;

    // Reset state
    tick();
    check_out("reset", 8'h01, 1'b0, 1'b0);
    rst = 1'b0;

    // Johnson right: 16-step cycle, wrap only on step 16
    for (int i = 0; i < 16; i++) begin
      tick();
      check_out($sformatf("johnson[%0d]", i), johnson_exp[i], (i == 15), 1'b0);
    end

    // Ring left: 8-step cycle with wrap on step 8, then reverse at 0x10
    bus.mode = 2'b01;
    bus.dir  = 1'b1;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_out($sformatf("ring[%0d]", i), 8'(1 << (i % 8)), (i == 8), 1'b0);
    end
    for (int i = 1; i <= 4; i++) tick();
    check("ring_at10", 32'(bus.cnt), 32'h10);
    bus.dir = 1'b0;
    tick();
    check_out("ring_rev1", 8'h08, 1'b0, 1'b0);
    tick();
    check_out("ring_rev2", 8'h04, 1'b0, 1'b0);

    // LFSR: full 255-state period from seed 1
    bus.mode = 2'b10;
    do_reset();
    model    = 8'h01;
    wraps    = 0;
    zeros    = 0;
    distinct = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      model = lfsr_next(model);
      check($sformatf("lfsr[%0d]", i), 32'(bus.cnt), 32'(model));
      if (bus.wrap) wraps++;
      if (bus.cnt == 8'h00) zeros++;
      if (!seen[bus.cnt]) begin
        seen[bus.cnt] = 1'b1;
        distinct++;
      end
    end
    check("lfsr_end", 32'(bus.cnt), 32'h01);
    check("lfsr_wraps", 32'(wraps), 32'd1);
    check("lfsr_zeros", 32'(zeros), 32'd0);
    check("lfsr_distinct", 32'(distinct), 32'd255);

    // Illegal Johnson load is shown once, then corrected
    bus.mode      = 2'b00;
    bus.load      = 1'b1;
    bus.load_data = 8'h5A;
    tick();
    check_out("ld5a", 8'h5A, 1'b0, 1'b0);
    bus.load = 1'b0;
    tick();
    check_out("ld5a_fix", 8'h01, 1'b0, 1'b1);
    tick();
    check_out("ld5a_step", 8'h00, 1'b0, 1'b0);

    // Zero is illegal for LFSR
    bus.mode      = 2'b10;
    bus.load      = 1'b1;
    bus.load_data = 8'h00;
    tick();
    check_out("ld00_lfsr", 8'h00, 1'b0, 1'b0);
    bus.load = 1'b0;
    tick();
    check_out("ld00_lfsr_fix", 8'h01, 1'b0, 1'b1);

    // Zero is legal for Johnson and keeps stepping
    bus.mode = 2'b00;
    bus.load = 1'b1;
    tick();
    check_out("ld00_john", 8'h00, 1'b0, 1'b0);
    bus.load = 1'b0;
    tick();
    check_out("ld00_john_step", 8'h80, 1'b0, 1'b0);

    // Hold via mode 11, then via en=0
    bus.mode = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out($sformatf("hold_m3[%0d]", i), 8'h80, 1'b0, 1'b0);
    end
    bus.mode = 2'b00;
    bus.en   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out($sformatf("hold_en0[%0d]", i), 8'h80, 1'b0, 1'b0);
    end

    // Mode switch from Johnson 0xC0 to ring corrects
    bus.en = 1'b1;
    tick();
    check_out("john_c0", 8'hC0, 1'b0, 1'b0);
    bus.mode = 2'b01;
    tick();
    check_out("switch_fix", 8'h01, 1'b0, 1'b1);

    // Reset overrides load
    rst           = 1'b1;
    bus.load      = 1'b1;
    bus.load_data = 8'h3C;
    tick();
    check_out("rst_ld", 8'h01, 1'b0, 1'b0);
    rst = 1'b0;

    // Load beats step in ring mode, then stepping resumes
    bus.load_data = 8'h80;
    tick();
    check_out("ld_en", 8'h80, 1'b0, 1'b0);
    bus.load = 1'b0;
    tick();
    check_out("ld_en_step", 8'h40, 1'b0, 1'b0);

    // Back-to-back loads: last one wins
    bus.mode      = 2'b11;
    bus.load      = 1'b1;
    bus.load_data = 8'h11;
    tick();
    bus.load_data = 8'h22;
    tick();
    bus.load = 1'b0;
    check_out("ld_b2b", 8'h22, 1'b0, 1'b0);
    tick();
    check_out("ld_b2b_hold", 8'h22, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
